// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one registered broadcast per cycle, chosen from NUM_UNITS requesters.
// Define CDB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 38
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD (`NUM_CDBBITS-1)
`endif

module cdb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int PAY_W     = `NUM_CDBBITS-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_UNITS-1:0]       req,
  input  logic [NUM_UNITS*PAY_W-1:0] payload,
  output logic [PAY_W:0]             cdb,
  output logic [NUM_UNITS-1:0]       grant,
  output logic                       conflict
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]                  base;
  logic [PTR_W-1:0]                  win_idx;
  logic [NUM_UNITS-1:0]              win_oh;
  logic [NUM_UNITS-1:0]              grant_nxt;
  logic                              found;
  logic                              conflict_nxt;
  logic [NUM_UNITS-1:0][PAY_W-1:0]   lane_pay;
  logic [PAY_W-1:0]                  bus_pay;

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr;

  // ptr only advances on a real broadcast; idle and flushed cycles leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (found && !flush)
      ptr <= (win_idx == PTR_W'(NUM_UNITS-1)) ? '0 : win_idx + 1'b1;
  end

  assign base = ptr;
`else
  logic unused_win_idx;
  assign unused_win_idx = ^win_idx;
  assign base = '0;
`endif

  // Search upward from base with wrap; first requester found wins.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    idx     = 0;
    cand    = '0;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int o = 0; o < NUM_UNITS; o++) begin
      idx  = (int'(base) + o) % NUM_UNITS;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

  assign grant_nxt    = flush ? '0 : win_oh;
  assign conflict_nxt = !flush && ((req & (req - 1'b1)) != '0);

  // One-hot gated OR mux: an idle bus carries zero payload, never stale data.
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
    assign lane_pay[g] = grant_nxt[g] ? payload[g*PAY_W +: PAY_W] : '0;
  end

  always_comb begin
    bus_pay = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      bus_pay = bus_pay | lane_pay[u];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb      <= '0;
      grant    <= '0;
      conflict <= 1'b0;
    end else begin
      cdb      <= {|grant_nxt, bus_pay};
      grant    <= grant_nxt;
      conflict <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter; expectations follow the RR macro the same way the DUT build does.
module tb_cdb_arbiter;
  localparam int N     = 4;
  localparam int PAY_W = 37;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*PAY_W-1:0] payload = '0;
  logic [PAY_W:0]     cdb;
  logic [N-1:0]       grant;
  logic               conflict;

  typedef struct packed {
    logic [PAY_W:0] cdb;
    logic [N-1:0]   grant;
    logic           conflict;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .payload(payload),
    .cdb(cdb), .grant(grant), .conflict(conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [PAY_W-1:0] mk(input int u, input logic [31:0] v);
    logic [2:0] rs;
    rs = 3'b001 << (u % 3);
    return {u[1:0], rs, v};
  endfunction

  function automatic exp_t predict(input logic [N-1:0] r, input logic [N*PAY_W-1:0] p, input logic f);
    exp_t x;
    int   k;
    int   i;
    x = '0;
    k = -1;
    if (!f && r != '0) begin
      for (int o = 0; o < N; o++) begin
        i = (m_ptr + o) % N;
        if (k < 0 && r[i]) k = i;
      end
      x.grant    = 4'b0001 << k;
      x.cdb      = {1'b1, p[k*PAY_W +: PAY_W]};
      x.conflict = $countones(r) > 1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
      m_ptr = (k + 1) % N;
`endif
    end
    return x;
  endfunction

  task automatic set_pay(input logic [31:0] base);
    for (int u = 0; u < N; u++) payload[u*PAY_W +: PAY_W] = mk(u, base + u);
  endtask

  task automatic step();
    sb.push_back(predict(req, payload, flush));
    @(posedge clk); #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; set_pay(32'h100);
    repeat (2) @(posedge clk); #1;
    total++;
    if (cdb !== '0 || grant !== '0 || conflict !== 1'b0) begin
      bad++; $display("FAIL reset_hold cdb=%h grant=%b conflict=%b want 0 0000 0", cdb, grant, conflict);
    end
    rst = 1'b0; m_ptr = 0; sb.delete();
    step();
    total++;
    if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict) begin
      bad++; $display("FAIL reset_first cdb=%h grant=%b conflict=%b want %h %b %b", cdb, grant, conflict, e.cdb, e.grant, e.conflict);
    end
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant got=%b want 0001", grant);
    end
    req = '0;
  endtask

  task automatic test_single();
    logic [PAY_W-1:0] mulpay;
    mulpay = {2'd2, 3'b010, 32'h0000_0006};
    payload[2*PAY_W +: PAY_W] = mulpay;
    req = 4'b0100;
    step();
    total++;
    if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict) begin
      bad++; $display("FAIL single cdb=%h grant=%b conflict=%b want %h %b %b", cdb, grant, conflict, e.cdb, e.grant, e.conflict);
    end
    total++;
    if (cdb !== {1'b1, mulpay} || grant !== 4'b0100 || conflict !== 1'b0) begin
      bad++; $display("FAIL single_literal cdb=%h grant=%b conflict=%b want %h 0100 0", cdb, grant, conflict, {1'b1, mulpay});
    end
    req = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict || cdb !== '0) begin
        bad++; $display("FAIL single_idle%0d cdb=%h grant=%b conflict=%b want 0 0000 0", c, cdb, grant, conflict);
      end
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] want;
    @(posedge clk); #1; rst = 1'b1; #2; rst = 1'b0; m_ptr = 0;
    req = 4'b1111; set_pay(32'h200);
    for (int c = 0; c < 5; c++) begin
      step();
`ifdef CDB_ARB_ROUND_ROBIN_EN
      want = 4'b0001 << (c % N);
`else
      want = 4'b0001;
`endif
      total++;
      if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict) begin
        bad++; $display("FAIL prio%0d cdb=%h grant=%b conflict=%b want %h %b %b", c, cdb, grant, conflict, e.cdb, e.grant, e.conflict);
      end
      total++;
      if (grant !== want || conflict !== 1'b1) begin
        bad++; $display("FAIL prio_seq%0d grant=%b conflict=%b want %b 1", c, grant, conflict, want);
      end
    end
    req = '0;
  endtask

  task automatic test_flush();
    req = 4'b0110; flush = 1'b1; set_pay(32'h300);
    step();
    total++;
    if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict || cdb !== '0 || grant !== '0) begin
      bad++; $display("FAIL flush_cycle cdb=%h grant=%b conflict=%b want 0 0000 0", cdb, grant, conflict);
    end
    flush = 1'b0;
    step();
    total++;
    if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict || grant !== 4'b0010) begin
      bad++; $display("FAIL flush_after cdb=%h grant=%b conflict=%b want %h 0010 %b", cdb, grant, conflict, e.cdb, e.conflict);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    req = 4'b1000; set_pay(32'h400);
    step();
    total++;
    if (cdb !== e.cdb || grant !== 4'b1000 || cdb[PAY_W] !== 1'b1) begin
      bad++; $display("FAIL div_bcast cdb=%h grant=%b want %h 1000", cdb, grant, e.cdb);
    end
    req = '0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (cdb !== '0 || grant !== '0 || conflict !== 1'b0) begin
      bad++; $display("FAIL async_reset cdb=%h grant=%b conflict=%b want 0 0000 0", cdb, grant, conflict);
    end
    @(posedge clk); #1;
    rst = 1'b0; m_ptr = 0; sb.delete();
  endtask

  task automatic test_back_to_back();
    req = 4'b0010; set_pay(32'h500);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict || grant !== 4'b0010) begin
        bad++; $display("FAIL hold%0d cdb=%h grant=%b conflict=%b want %h 0010 %b", c, cdb, grant, conflict, e.cdb, e.conflict);
      end
    end
    for (int c = 0; c < 60; c++) begin
      req   = N'($urandom_range(0, 15));
      flush = ($urandom_range(0, 5) == 0);
      for (int u = 0; u < N; u++) payload[u*PAY_W +: PAY_W] = mk(u, $urandom());
      step();
      total++;
      if (cdb !== e.cdb || grant !== e.grant || conflict !== e.conflict) begin
        bad++; $display("FAIL rand%0d cdb=%h grant=%b conflict=%b want %h %b %b", c, cdb, grant, conflict, e.cdb, e.grant, e.conflict);
      end
    end
    req = '0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
